// File: rtl/conv_viterbi_decoder_if.sv
// Streaming bus for conv_viterbi_decoder.
//   i_sym / i_sym_valid / o_sym_ready   : received hard-symbol stream into the decoder
//   o_bit / o_bit_valid / o_bit_last / i_bit_ready : decoded info-bit stream out of the decoder
// master: the side that feeds symbols and sinks bits; slave: the decoder.
interface conv_viterbi_decoder_if #(
  parameter int CODE_RATE = 2
) ();
  logic [CODE_RATE-1:0] i_sym;
  logic                 i_sym_valid;
  logic                 o_sym_ready;
  logic                 o_bit;
  logic                 o_bit_valid;
  logic                 o_bit_last;
  logic                 i_bit_ready;

  modport master (
    output i_sym, i_sym_valid, i_bit_ready,
    input  o_sym_ready, o_bit, o_bit_valid, o_bit_last
  );

  modport slave (
    input  i_sym, i_sym_valid, i_bit_ready,
    output o_sym_ready, o_bit, o_bit_valid, o_bit_last
  );
endinterface

// File: rtl/conv_viterbi_decoder.sv
// Hard-decision, frame-based, zero-tail Viterbi decoder (receive side of the
// convolutional encoder; same polynomial format, bit order and state convention).
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   i_gen_poly      : [CODE_RATE][K] taps, [i][k] taps history bit k (k=0 current input)
//   i_start         : begin-frame pulse, honoured only in IDLE
//   i_frame_len     : total symbols L including K-1 tail symbols, sampled with i_start
//   io (slave)      : symbol stream in (i_sym/i_sym_valid/o_sym_ready),
//                     decoded bit stream out (o_bit/o_bit_valid/o_bit_last/i_bit_ready)
//   o_busy          : any state other than IDLE
//   o_err           : one-cycle pulse on an illegal frame length
module conv_viterbi_decoder #(
  parameter int K         = 3,
  parameter int CODE_RATE = 2,
  parameter int MAX_FRAME = 64,
  parameter int PM_W      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CODE_RATE-1:0][K-1:0]         i_gen_poly,
  input  logic                                i_start,
  input  logic [$clog2(MAX_FRAME+1)-1:0]      i_frame_len,
  conv_viterbi_decoder_if.slave               io,
  output logic                                o_busy,
  output logic                                o_err
);

  localparam int unsigned S  = 2 ** (K - 1);
  localparam int          LW = $clog2(MAX_FRAME + 1);
  localparam int          TW = $clog2(MAX_FRAME);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACS   = 2'd1;
  localparam logic [1:0] ST_TRACE = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [1:0]                  r_state;
  logic [CODE_RATE-1:0][K-1:0] r_poly;
  logic [TW-1:0]               r_last_t;    // L-1: final trellis step
  logic [TW-1:0]               r_last_out;  // L-K: index of the last info bit
  logic [TW-1:0]               r_t;
  logic [TW-1:0]               r_idx;
  logic [PM_W-1:0]             r_pm [S];
  logic [S-1:0]                r_dec [MAX_FRAME];
  logic [MAX_FRAME-1:0]        r_bitbuf;
  logic [K-2:0]                r_tb_s;
  logic                        r_tb_go;
  logic                        r_bit;
  logic                        r_bit_valid;
  logic                        r_bit_last;
  logic                        r_err;

  logic [PM_W-1:0]             w_pm_nxt [S];
  logic [S-1:0]                w_dec;
  logic                        w_sym_fire;
  logic                        w_len_ok;

  assign w_sym_fire = (r_state == ST_ACS) && io.i_sym_valid;
  assign w_len_ok   = (i_frame_len >= LW'(K)) && (i_frame_len <= LW'(MAX_FRAME));

  assign io.o_sym_ready = (r_state == ST_ACS);
  assign io.o_bit       = r_bit;
  assign io.o_bit_valid = r_bit_valid;
  assign io.o_bit_last  = r_bit_last;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_err          = r_err;

  // Expected code symbol for a K-bit history {predecessor, input}.
  function automatic logic [CODE_RATE-1:0] f_expect(
    input logic [K-1:0]                hist,
    input logic [CODE_RATE-1:0][K-1:0] g
  );
    logic [CODE_RATE-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < CODE_RATE; i++) e[i] = ^(hist & g[i]);
    return e;
  endfunction

  // Path metric plus Hamming weight of the symbol difference, saturating.
  function automatic logic [PM_W-1:0] f_sat_add(
    input logic [PM_W-1:0]      pm,
    input logic [CODE_RATE-1:0] diff
  );
    logic [PM_W:0] sum;
    sum = {1'b0, pm};
    for (int unsigned i = 0; i < CODE_RATE; i++) sum = sum + (PM_W+1)'(diff[i]);
    return sum[PM_W] ? '1 : sum[PM_W-1:0];
  endfunction

  // Add-compare-select across all states; ties keep the b=0 predecessor.
  always_comb begin
    logic [K-2:0]    st;
    logic [K-2:0]    p0;
    logic [K-2:0]    p1;
    logic [PM_W-1:0] c0;
    logic [PM_W-1:0] c1;
    st    = '0;
    p0    = '0;
    p1    = '0;
    c0    = '0;
    c1    = '0;
    w_dec = '0;
    for (int unsigned s = 0; s < S; s++) w_pm_nxt[s] = '0;
    for (int unsigned s = 0; s < S; s++) begin
      st = (K-1)'(s);
      p0 = {1'b0, st[K-2:1]};
      p1 = {1'b1, st[K-2:1]};
      c0 = f_sat_add(r_pm[p0], io.i_sym ^ f_expect({p0, st[0]}, r_poly));
      c1 = f_sat_add(r_pm[p1], io.i_sym ^ f_expect({p1, st[0]}, r_poly));
      if (c1 < c0) begin
        w_pm_nxt[s] = c1;
        w_dec[s]    = 1'b1;
      end else begin
        w_pm_nxt[s] = c0;
      end
    end
  end

  // Survivor decisions and traced-back bits; contents are meaningless outside a frame.
  always_ff @(posedge clk) begin
    if (w_sym_fire) r_dec[r_t] <= w_dec;
    if ((r_state == ST_TRACE) && r_tb_go) r_bitbuf[r_t] <= r_tb_s[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_poly      <= '0;
      r_last_t    <= '0;
      r_last_out  <= '0;
      r_t         <= '0;
      r_idx       <= '0;
      r_tb_s      <= '0;
      r_tb_go     <= 1'b0;
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
      r_bit_last  <= 1'b0;
      r_err       <= 1'b0;
      for (int unsigned s = 0; s < S; s++) r_pm[s] <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_len_ok) begin
              r_poly     <= i_gen_poly;
              r_last_t   <= TW'(i_frame_len - LW'(1));
              r_last_out <= TW'(i_frame_len - LW'(K));
              r_t        <= '0;
              for (int unsigned s = 0; s < S; s++)
                r_pm[s] <= (s == 0) ? '0 : PM_W'(2 ** (PM_W - 2));
              r_state    <= ST_ACS;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_ACS: begin
          if (w_sym_fire) begin
            for (int unsigned s = 0; s < S; s++) r_pm[s] <= w_pm_nxt[s];
            if (r_t == r_last_t) begin
              r_tb_go <= 1'b0;
              r_state <= ST_TRACE;
            end else begin
              r_t <= r_t + TW'(1);
            end
          end
        end
        ST_TRACE: begin
          // First TRACE cycle only seeds the traceback (state 0, time L-1);
          // the following L cycles each emit one bit into the buffer.
          if (!r_tb_go) begin
            r_tb_go <= 1'b1;
            r_t     <= r_last_t;
            r_tb_s  <= '0;
          end else begin
            r_tb_s <= {r_dec[r_t][r_tb_s], r_tb_s[K-2:1]};
            if (r_t == '0) begin
              r_idx       <= '0;
              r_bit_valid <= 1'b0;
              r_state     <= ST_OUT;
            end else begin
              r_t <= r_t - TW'(1);
            end
          end
        end
        ST_OUT: begin
          if (!r_bit_valid) begin
            r_bit       <= r_bitbuf[r_idx];
            r_bit_valid <= 1'b1;
            r_bit_last  <= (r_idx == r_last_out);
          end else if (io.i_bit_ready) begin
            if (r_bit_last) begin
              r_bit_valid <= 1'b0;
              r_bit_last  <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_idx      <= r_idx + TW'(1);
              r_bit      <= r_bitbuf[r_idx + TW'(1)];
              r_bit_last <= ((r_idx + TW'(1)) == r_last_out);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_viterbi_decoder.sv
module tb_conv_viterbi_decoder;
  localparam int K  = 3;
  localparam int CR = 2;
  localparam int MF = 64;
  localparam int PW = 8;
  localparam int LW = $clog2(MF + 1);

  logic clk = 1'b0;
  logic rst;
  logic [CR-1:0][K-1:0] gen_poly;
  logic start;
  logic [LW-1:0] frame_len;
  logic busy;
  logic err;

  always #5 clk = ~clk;

  conv_viterbi_decoder_if #(.CODE_RATE(CR)) bus ();

  conv_viterbi_decoder #(.K(K), .CODE_RATE(CR), .MAX_FRAME(MF), .PM_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_gen_poly  (gen_poly),
    .i_start     (start),
    .i_frame_len (frame_len),
    .io          (bus),
    .o_busy      (busy),
    .o_err       (err)
  );

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_pulses = 0;
  bit   bp_mode = 1'b0;

  // Generator taps: taps[i][k] = 1 when row i uses the input k steps ago.
  int taps[CR][K] = '{'{1, 1, 1}, '{1, 0, 1}};
  int info[MF];
  logic [CR-1:0] syms[MF];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic logic [CR-1:0][K-1:0] ref_poly();
    logic [CR-1:0][K-1:0] p;
    p = '0;
    for (int i = 0; i < CR; i++)
      for (int k = 0; k < K; k++) p[i][k] = (taps[i][k] != 0);
    return p;
  endfunction

  // Reference encoder: code bit i at time t is the parity of the tapped past inputs.
  function automatic void encode(input int n_info);
    int L;
    L = n_info + K - 1;
    for (int t = 0; t < L; t++) begin
      for (int i = 0; i < CR; i++) begin
        int acc;
        acc = 0;
        for (int k = 0; k < K; k++)
          if (t - k >= 0 && t - k < n_info && taps[i][k] != 0) acc += info[t-k];
        syms[t][i] = logic'(acc % 2);
      end
    end
  endfunction

  // Bit-sink ready: either always ready or the repeating 1,0,0,1 pattern.
  initial begin
    int ph;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    ph = 0;
    bus.i_bit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        bus.i_bit_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        bus.i_bit_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every bit handshake, checks stall stability.
  initial begin
    bit   st_prev;
    logic st_bit;
    logic st_last;
    exp_t e;
    st_prev = 1'b0;
    st_bit  = 1'b0;
    st_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        st_prev = 1'b0;
      end else begin
        if (err) err_pulses++;
        if (bus.o_bit_valid) begin
          if (st_prev) begin
            check("stall_bit", bus.o_bit, st_bit);
            check("stall_last", bus.o_bit_last, st_last);
          end
          if (bus.i_bit_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_bit: got %0d expected no output", bus.o_bit);
            end else begin
              e = exp_q.pop_front();
              check("bit", bus.o_bit, e.b);
              check("bit_last", bus.o_bit_last, e.last);
            end
            st_prev = 1'b0;
          end else begin
            st_prev = 1'b1;
            st_bit  = bus.o_bit;
            st_last = bus.o_bit_last;
          end
        end else begin
          if (st_prev) check("stall_valid", bus.o_bit_valid, 1);
          st_prev = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_sym_valid = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_sym_ready"}, bus.o_sym_ready, 0);
    check({tag, "_bit_valid"}, bus.o_bit_valid, 0);
    check({tag, "_bit"},       bus.o_bit, 0);
    check({tag, "_bit_last"},  bus.o_bit_last, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_err"},       err, 0);
  endtask

  task automatic start_frame(input int L);
    @(posedge clk);
    #1;
    gen_poly  = ref_poly();
    start     = 1'b1;
    frame_len = LW'(L);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_sym(input logic [CR-1:0] v, output bit ok);
    bus.i_sym       = v;
    bus.i_sym_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (bus.o_sym_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.i_sym_valid = 1'b0;
  endtask

  task automatic run_frame(input int n_info, input int nerr, input int force_t,
                           input logic [CR-1:0] force_v, input bit gaps,
                           input bit bp, input bit poke);
    int L;
    int err0;
    int n;
    int p1;
    int p2;
    bit ok;
    L = n_info + K - 1;
    encode(n_info);
    if (force_t >= 0) syms[force_t] = force_v;
    p1 = $urandom_range(0, L*CR - 1);
    p2 = (p1 + 1 + $urandom_range(0, L*CR - 2)) % (L*CR);
    if (nerr >= 1) syms[p1/CR][p1%CR] = ~syms[p1/CR][p1%CR];
    if (nerr >= 2) syms[p2/CR][p2%CR] = ~syms[p2/CR][p2%CR];
    for (int j = 0; j < n_info; j++) exp_q.push_back('{b: logic'(info[j]), last: (j == n_info - 1)});
    err0 = err_pulses;
    start_frame(L);
    gen_poly = (CR*K)'($urandom);
    bp_mode = bp;
    for (int t = 0; t < L; t++) begin
      if (poke && t == 2) begin
        start     = 1'b1;
        frame_len = LW'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
      send_sym(syms[t], ok);
      if (!ok) begin
        fail_timeout("sym_accept");
        exp_q.delete();
        bp_mode = 1'b0;
        do_reset();
        return;
      end
    end
    n = 0;
    ok = 1'b0;
    for (int w = 0; w < 400; w++) begin
      @(negedge clk);
      if (bus.o_bit_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    if (!ok) fail_timeout("first_bit");
    else check("latency", n, L + 2);
    ok = 1'b0;
    for (int w = 0; w < 3000; w++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_timeout("drain");
      exp_q.delete();
      bp_mode = 1'b0;
      do_reset();
      return;
    end
    @(negedge clk);
    check("valid_after_last", bus.o_bit_valid, 0);
    check("busy_after_last", busy, 0);
    check("no_err_in_frame", err_pulses, err0);
    bp_mode = 1'b0;
  endtask

  task automatic illegal_len(input int L);
    @(posedge clk);
    #1;
    start     = 1'b1;
    frame_len = LW'(L);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    @(negedge clk);
    check("err_one_cycle", err, 0);
    check("err_busy2", busy, 0);
  endtask

  initial begin
    int exp_syms[6];
    bit ok;
    exp_syms = '{3, 1, 0, 2, 2, 3};
    rst = 1'b0;
    start = 1'b0;
    frame_len = '0;
    gen_poly = ref_poly();
    bus.i_sym = '0;
    bus.i_sym_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check_all_zero("reset");

    // Directed frame 1,0,1,1 and its reference encoding.
    info[0] = 1; info[1] = 0; info[2] = 1; info[3] = 1;
    encode(4);
    for (int t = 0; t < 6; t++) check("ref_encode", syms[t], exp_syms[t]);
    run_frame(4, 0, -1, '0, 1'b0, 1'b0, 1'b0);
    run_frame(4, 0, 2, 2'd1, 1'b0, 1'b0, 1'b0);

    illegal_len(2);
    illegal_len(65);

    // Reset in the middle of symbol acceptance, then a clean frame.
    start_frame(6);
    for (int t = 0; t < 3; t++) begin
      send_sym(syms[t], ok);
      if (!ok) fail_timeout("abort_sym_accept");
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_all_zero("mid_reset");
    check("mid_reset_queue", exp_q.size(), 0);
    run_frame(4, 0, -1, '0, 1'b0, 1'b0, 1'b0);

    // Longest all-zero frame.
    for (int j = 0; j < 62; j++) info[j] = 0;
    run_frame(62, 0, -1, '0, 1'b0, 1'b0, 1'b0);

    // Shortest frame: exactly one info bit.
    info[0] = 1;
    run_frame(1, 0, -1, '0, 1'b0, 1'b1, 1'b0);

    // Backpressure, symbol gaps and an ignored mid-frame start.
    info[0] = 1; info[1] = 0; info[2] = 1; info[3] = 1;
    run_frame(4, 0, -1, '0, 1'b1, 1'b1, 1'b1);

    // Randomised frames with up to two channel errors.
    for (int f = 0; f < 10; f++) begin
      int ni;
      ni = $urandom_range(1, 62);
      for (int j = 0; j < ni; j++) info[j] = int'($urandom_range(0, 1));
      run_frame(ni, $urandom_range(0, 2), -1, '0, bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'(f % 3 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

endmodule

// File: doc/conv_viterbi_decoder.md
Name: conv_viterbi_decoder

Overview:
Hard-decision, frame-based Viterbi decoder: the receive-side counterpart of the team's convolutional encoder. Uses the same generator-polynomial format, bit ordering and state convention. Accepts one CODE_RATE-bit symbol per handshake and runs add-compare-select (ACS) over all states in parallel. After the frame it traces back from state 0 (zero-tail terminated) and streams the decoded information bits out in original order.

Parameters:
K, 3, constraint length; STATE_NUM = 2^(K-1)
CODE_RATE, 2, coded bits per info bit (n in 1/n)
MAX_FRAME, 64, max symbols per frame including K-1 tail symbols
PM_W, 8, path-metric width; adds saturate at 2^PM_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
i_gen_poly  in  [CODE_RATE][K]  gen_poly[i][k] taps history bit k (k=0 is current input), same as encoder
i_start  in  1  one-cycle pulse, begin frame (accepted only in IDLE)
i_frame_len  in  clog2(MAX_FRAME+1)  L = total symbols incl. tail, sampled with i_start
i_sym  in  CODE_RATE  received hard symbol; bit i corresponds to gen_poly row i
i_sym_valid  in  1  symbol valid
o_sym_ready  out  1  high in ACS state
o_bit  out  1  decoded info bit
o_bit_valid  out  1  o_bit valid
o_bit_last  out  1  marks last info bit
i_bit_ready  in  1  sink ready
o_busy  out  1  high in any state except IDLE
o_err  out  1  one-cycle pulse: illegal frame length

Behaviour:
- Reset (rst=0 at a clock edge, in any state, including mid-frame): FSM=IDLE; o_sym_ready, o_bit, o_bit_valid, o_bit_last, o_busy, o_err all 0; counters 0; the frame in progress is discarded.
- FSM: IDLE -> ACS -> TRACE -> OUT -> IDLE.
- IDLE:
  - i_start with K <= L <= MAX_FRAME: latch L and i_gen_poly, set PM[0]=0 and PM[s!=0]=2^(PM_W-2), t=0, go to ACS.
  - Illegal L: o_err=1 for one cycle, stay IDLE.
  - i_start outside IDLE: ignored.
- State convention: next_state = {state[K-3:0], u}. Predecessors of s are p_b = {b, s[K-2:1]}, b in {0,1}, with input u = s[0]. Expected symbol bit i = XOR over k of ({p_b,u}[k] & g[i][k]).
- ACS: one symbol per cycle when i_sym_valid & o_sym_ready.
  - BM = Hamming distance(i_sym, expected).
  - cand_b = sat(PM[p_b] + BM_b).
  - Select min; on a tie select b=0.
  - Store decision bit b into survivor memory [t][s].
  - All PM update in the same cycle.
  - After symbol L-1 is accepted (t==L-1), next cycle: o_sym_ready=0, go to TRACE.
  - i_sym_valid low: hold, no update.
- TRACE: start at state 0 and time L-1, one step per cycle.
  - Decoded bit u_t = s[0]; write bitbuf[t] = u_t.
  - s <= {dec[t][s], s[K-2:1]}; t--.
  - Exactly L cycles, then go to OUT.
- OUT: emit bitbuf[0 .. L-K] in order (L-K+1 info bits; tail not emitted).
  - o_bit_valid stays high until i_bit_ready; advance only on valid & ready.
  - o_bit/o_bit_valid are registered and stable while stalled.
  - o_bit_last=1 with index L-K.
  - After the last handshake, go to IDLE; o_bit_valid drops in the same edge.
- Latency: after the last symbol handshake, the first o_bit_valid occurs L+2 cycles later (1 transition cycle, L traceback cycles, 1 register load).
- i_gen_poly changes mid-frame have no effect (latched copy used).
- L=K: exactly one info bit is output, with o_bit_last set.

Test Plan:
- Reset mid-ACS after 3 of 6 symbols -> all outputs 0 next cycle; new i_start with L=6 decodes correctly.
- K=3, g0=3'b111, g1=3'b101, L=6, symbols (hex, {g1,g0}) 3,1,0,2,2,3 -> o_bit 1,0,1,1; o_bit_last on 4th bit; o_err never set.
- Same frame with symbol 2 corrupted to 1 (single-bit error) -> still 1,0,1,1.
- All-zero frame, L=64, symbols 0 -> 62 zero bits, last flagged at bit 62; PM[0] remains 0.
- i_frame_len=2 and 65 -> o_err one-cycle pulse each, o_busy stays 0; i_start asserted during ACS is ignored.
- Backpressure: i_bit_ready toggling 1,0,0,1 and i_sym_valid gaps -> same decoded sequence; o_bit stable during stalls; no lost or duplicated bits.
